// File: rtl/any1_bitfield_rs_if.sv
// Dispatch, result-bus and issue bundle of the bitfield reservation station.
// slave: station side; master: dispatcher/CDB/bitfield-unit side.
interface any1_bitfield_rs_if #(
    parameter int TAGW   = 5,
    parameter int DWIDTH = 64,
    parameter int IWIDTH = 32
);
    logic                  disp_v_i;
    logic                  disp_rdy_o;
    logic [IWIDTH-1:0]     disp_inst_i;
    logic [TAGW-1:0]       disp_tag_i;
    logic [3:0]            disp_opv_i;
    logic [4*DWIDTH-1:0]   disp_opd_i;
    logic [4*TAGW-1:0]     disp_opt_i;

    logic                  cdb_v_i;
    logic [TAGW-1:0]       cdb_tag_i;
    logic [DWIDTH-1:0]     cdb_val_i;

    logic                  iss_v_o;
    logic                  iss_rdy_i;
    logic [IWIDTH-1:0]     iss_inst_o;
    logic [TAGW-1:0]       iss_tag_o;
    logic [DWIDTH-1:0]     iss_a_o;
    logic [DWIDTH-1:0]     iss_b_o;
    logic [DWIDTH-1:0]     iss_c_o;
    logic [DWIDTH-1:0]     iss_d_o;

    modport slave (
        input  disp_v_i, disp_inst_i, disp_tag_i,
        input  disp_opv_i, disp_opd_i, disp_opt_i,
        input  cdb_v_i, cdb_tag_i, cdb_val_i, iss_rdy_i,
        output disp_rdy_o, iss_v_o, iss_inst_o, iss_tag_o,
        output iss_a_o, iss_b_o, iss_c_o, iss_d_o
    );

    modport master (
        output disp_v_i, disp_inst_i, disp_tag_i,
        output disp_opv_i, disp_opd_i, disp_opt_i,
        output cdb_v_i, cdb_tag_i, cdb_val_i, iss_rdy_i,
        input  disp_rdy_o, iss_v_o, iss_inst_o, iss_tag_o,
        input  iss_a_o, iss_b_o, iss_c_o, iss_d_o
    );
endinterface

// File: rtl/any1_bitfield_rs.sv
// Bitfield reservation station: holds dispatched ops, snoops the CDB,
// issues the oldest ready op into a registered valid/ready issue port.
// Ports: clk_i, rst_i (sync, high), flush_i, bus (slave), count_o.
module any1_bitfield_rs #(
    parameter int NENTRIES = 4,
    parameter int TAGW     = 5,
    parameter int DWIDTH   = 64,
    parameter int IWIDTH   = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    any1_bitfield_rs_if.slave             bus,
    output logic [$clog2(NENTRIES):0]     count_o
);
    localparam int IW = $clog2(NENTRIES);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] FULL = CW'(NENTRIES);

    logic [NENTRIES-1:0] vld;
    logic [IWIDTH-1:0]   inst [NENTRIES];
    logic [TAGW-1:0]     tag  [NENTRIES];
    logic [3:0]          rdy  [NENTRIES];
    logic [DWIDTH-1:0]   val  [NENTRIES][4];
    logic [TAGW-1:0]     ptag [NENTRIES][4];
    // rank = age order among valid entries, 0 is oldest
    logic [CW-1:0]       rank [NENTRIES];
    logic [CW-1:0]       cnt;

    logic                iss_v;
    logic [IWIDTH-1:0]   iss_inst;
    logic [TAGW-1:0]     iss_tag;
    logic [DWIDTH-1:0]   iss_op [4];

    logic                found;
    logic [IW-1:0]       win;
    logic [CW-1:0]       wrank;
    logic                ffound;
    logic [IW-1:0]       fidx;
    logic                load;
    logic                acc;
    logic [CW-1:0]       nrank;

    always_comb begin
        found  = 1'b0;
        win    = '0;
        wrank  = '0;
        ffound = 1'b0;
        fidx   = '0;
        for (int i = 0; i < NENTRIES; i++) begin
            if (vld[i] && (&rdy[i]) && (!found || rank[i] < wrank)) begin
                found = 1'b1;
                win   = IW'(i);
                wrank = rank[i];
            end
            if (!vld[i] && !ffound) begin
                ffound = 1'b1;
                fidx   = IW'(i);
            end
        end
    end

    assign load  = (!iss_v || bus.iss_rdy_i) && found && !flush_i;
    assign acc   = bus.disp_v_i && (cnt != FULL) && !flush_i;
    // new entry ranks behind everything that survives this cycle
    assign nrank = cnt - CW'(load);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            vld   <= '0;
            cnt   <= '0;
            iss_v <= 1'b0;
            if (rst_i) begin
                iss_inst <= '0;
                iss_tag  <= '0;
                for (int k = 0; k < 4; k++) iss_op[k] <= '0;
            end
        end else begin
            for (int i = 0; i < NENTRIES; i++) begin
                for (int k = 0; k < 4; k++) begin
                    if (vld[i] && !rdy[i][k] && bus.cdb_v_i &&
                        ptag[i][k] == bus.cdb_tag_i) begin
                        rdy[i][k] <= 1'b1;
                        val[i][k] <= bus.cdb_val_i;
                    end
                end
                if (load && vld[i] && rank[i] > wrank)
                    rank[i] <= rank[i] - CW'(1);
            end
            if (load) begin
                vld[win] <= 1'b0;
                iss_v    <= 1'b1;
                iss_inst <= inst[win];
                iss_tag  <= tag[win];
                for (int k = 0; k < 4; k++) iss_op[k] <= val[win][k];
            end else if (bus.iss_rdy_i) begin
                iss_v <= 1'b0;
            end
            if (acc) begin
                vld[fidx]  <= 1'b1;
                inst[fidx] <= bus.disp_inst_i;
                tag[fidx]  <= bus.disp_tag_i;
                rank[fidx] <= nrank;
                for (int k = 0; k < 4; k++) begin
                    ptag[fidx][k] <= bus.disp_opt_i[k*TAGW +: TAGW];
                    if (bus.disp_opv_i[k]) begin
                        rdy[fidx][k] <= 1'b1;
                        val[fidx][k] <= bus.disp_opd_i[k*DWIDTH +: DWIDTH];
                    end else if (bus.cdb_v_i && bus.cdb_tag_i ==
                                 bus.disp_opt_i[k*TAGW +: TAGW]) begin
                        rdy[fidx][k] <= 1'b1;
                        val[fidx][k] <= bus.cdb_val_i;
                    end else begin
                        rdy[fidx][k] <= 1'b0;
                    end
                end
            end
            case ({acc, load})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign count_o        = cnt;
    assign bus.disp_rdy_o = (cnt != FULL);
    assign bus.iss_v_o    = iss_v;
    assign bus.iss_inst_o = iss_inst;
    assign bus.iss_tag_o  = iss_tag;
    assign bus.iss_a_o    = iss_op[0];
    assign bus.iss_b_o    = iss_op[1];
    assign bus.iss_c_o    = iss_op[2];
    assign bus.iss_d_o    = iss_op[3];
endmodule

// File: tb/tb_any1_bitfield_rs.sv
// Self-checking bench for any1_bitfield_rs: directed scenarios plus
// random traffic against an age-ordered queue model of the station.
module tb_any1_bitfield_rs;
    localparam int NE = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [2:0] count;
    int         checks = 0;
    int         errors = 0;

    any1_bitfield_rs_if #(.TAGW(5), .DWIDTH(64), .IWIDTH(32)) bus ();

    any1_bitfield_rs #(
        .NENTRIES(NE), .TAGW(5), .DWIDTH(64), .IWIDTH(32)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus),
        .count_o (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      inst;
        logic [4:0]       tag;
        logic [3:0]       rdy;
        logic [3:0][63:0] val;
        logic [3:0][4:0]  pt;
    } ent_t;

    ent_t q[$];
    logic m_v = 1'b0;
    ent_t m_iss;

    task automatic chk(input string nm, input logic [63:0] o,
                       input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", nm, o, e);
        end
    endtask

    // Next-state of the station in terms of an oldest-first queue
    task automatic model_step();
        int   c;
        logic ld;
        logic ac;
        ent_t e;
        if (rst || flush) begin
            q.delete();
            m_v = 1'b0;
            if (rst) m_iss = '0;
            return;
        end
        c = -1;
        foreach (q[i]) if (c < 0 && q[i].rdy == 4'hF) c = i;
        ld = (!m_v || bus.iss_rdy_i) && c >= 0;
        ac = bus.disp_v_i && q.size() != NE;
        if (ld) begin
            m_v   = 1'b1;
            m_iss = q[c];
            q.delete(c);
        end else if (bus.iss_rdy_i) begin
            m_v = 1'b0;
        end
        foreach (q[i])
            for (int k = 0; k < 4; k++)
                if (!q[i].rdy[k] && bus.cdb_v_i &&
                    q[i].pt[k] == bus.cdb_tag_i) begin
                    q[i].rdy[k] = 1'b1;
                    q[i].val[k] = bus.cdb_val_i;
                end
        if (ac) begin
            e      = '0;
            e.inst = bus.disp_inst_i;
            e.tag  = bus.disp_tag_i;
            for (int k = 0; k < 4; k++) begin
                e.pt[k] = bus.disp_opt_i[k*5 +: 5];
                if (bus.disp_opv_i[k]) begin
                    e.rdy[k] = 1'b1;
                    e.val[k] = bus.disp_opd_i[k*64 +: 64];
                end else if (bus.cdb_v_i && bus.cdb_tag_i == e.pt[k]) begin
                    e.rdy[k] = 1'b1;
                    e.val[k] = bus.cdb_val_i;
                end
            end
            q.push_back(e);
        end
    endtask

    task automatic check_all();
        chk("iss_v", 64'(bus.iss_v_o), 64'(m_v));
        if (m_v) begin
            chk("iss_inst", 64'(bus.iss_inst_o), 64'(m_iss.inst));
            chk("iss_tag", 64'(bus.iss_tag_o), 64'(m_iss.tag));
            chk("iss_a", bus.iss_a_o, m_iss.val[0]);
            chk("iss_b", bus.iss_b_o, m_iss.val[1]);
            chk("iss_c", bus.iss_c_o, m_iss.val[2]);
            chk("iss_d", bus.iss_d_o, m_iss.val[3]);
        end
        chk("count", 64'(count), 64'(q.size()));
        chk("disp_rdy", 64'(bus.disp_rdy_o), 64'(q.size() != NE));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic disp(input logic [4:0] t, input logic [3:0] v,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c, input logic [63:0] d,
                        input logic [19:0] pts);
        bus.disp_v_i    = 1'b1;
        bus.disp_inst_i = 32'h1000 + 32'(t);
        bus.disp_tag_i  = t;
        bus.disp_opv_i  = v;
        bus.disp_opd_i  = {d, c, b, a};
        bus.disp_opt_i  = pts;
    endtask

    task automatic cdb(input logic v, input logic [4:0] t,
                       input logic [63:0] x);
        bus.cdb_v_i   = v;
        bus.cdb_tag_i = t;
        bus.cdb_val_i = x;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.disp_v_i = 1'b0;
        bus.disp_inst_i = '0;
        bus.disp_tag_i = '0;
        bus.disp_opv_i = '0;
        bus.disp_opd_i = '0;
        bus.disp_opt_i = '0;
        bus.iss_rdy_i = 1'b1;
        cdb(1'b0, 5'd0, 64'd0);
        m_iss = '0;
        tick();
        tick();
        chk("rst_inst", 64'(bus.iss_inst_o), 64'd0);
        chk("rst_tag", 64'(bus.iss_tag_o), 64'd0);
        chk("rst_a", bus.iss_a_o, 64'd0);
        chk("rst_d", bus.iss_d_o, 64'd0);
        rst = 1'b0;

        // single fully-ready op: 2-cycle dispatch-to-issue
        disp(5'd3, 4'hF, 64'h0, 64'h0, 64'd4, 64'd3, 20'h0);
        tick();
        bus.disp_v_i = 1'b0;
        chk("t1_count1", 64'(count), 64'd1);
        chk("t1_v0", 64'(bus.iss_v_o), 64'd0);
        tick();
        chk("t1_v1", 64'(bus.iss_v_o), 64'd1);
        chk("t1_tag", 64'(bus.iss_tag_o), 64'd3);
        chk("t1_c", bus.iss_c_o, 64'd4);
        chk("t1_d", bus.iss_d_o, 64'd3);
        chk("t1_count0", 64'(count), 64'd0);
        tick();

        // younger ready op overtakes older waiting one
        disp(5'd1, 4'b1110, 64'h0, 64'h5, 64'd1, 64'd1, {15'h0, 5'd9});
        tick();
        disp(5'd2, 4'hF, 64'h7, 64'h8, 64'd2, 64'd2, 20'h0);
        tick();
        bus.disp_v_i = 1'b0;
        tick();
        chk("t2_first", 64'(bus.iss_tag_o), 64'd2);
        cdb(1'b1, 5'd9, 64'hFF00);
        tick();
        cdb(1'b0, 5'd0, 64'd0);
        tick();
        chk("t2_second", 64'(bus.iss_tag_o), 64'd1);
        chk("t2_a", bus.iss_a_o, 64'hFF00);
        tick();
        tick();

        // fill while stalled, then drain in dispatch order
        bus.iss_rdy_i = 1'b0;
        for (int t = 10; t < 15; t++) begin
            disp(5'(t), 4'hF, 64'(t), 64'd0, 64'd1, 64'd2, 20'h0);
            tick();
        end
        chk("t3_full", 64'(bus.disp_rdy_o), 64'd0);
        chk("t3_hold", 64'(bus.iss_tag_o), 64'd10);
        disp(5'd15, 4'hF, 64'd15, 64'd0, 64'd1, 64'd2, 20'h0);
        tick();
        chk("t3_hold2", 64'(bus.iss_tag_o), 64'd10);
        chk("t3_cnt", 64'(count), 64'd4);
        bus.disp_v_i = 1'b0;
        bus.iss_rdy_i = 1'b1;
        for (int t = 11; t < 15; t++) begin
            tick();
            chk("t3_order", 64'(bus.iss_tag_o), 64'(t));
        end
        tick();
        chk("t3_empty", 64'(bus.iss_v_o), 64'd0);

        // same-cycle CDB bypass on dispatch
        disp(5'd4, 4'b1101, 64'h1, 64'h0, 64'd5, 64'd6, {10'h0, 5'd7, 5'd0});
        cdb(1'b1, 5'd7, 64'h1234);
        tick();
        bus.disp_v_i = 1'b0;
        cdb(1'b0, 5'd0, 64'd0);
        tick();
        chk("t4_tag", 64'(bus.iss_tag_o), 64'd4);
        chk("t4_b", bus.iss_b_o, 64'h1234);
        tick();

        // one CDB wakes three entries
        for (int t = 20; t < 23; t++) begin
            disp(5'(t), 4'b1011, 64'(t), 64'd0, 64'd0, 64'd1,
                 {5'd0, 5'd5, 10'd0});
            tick();
        end
        bus.disp_v_i = 1'b0;
        cdb(1'b1, 5'd5, 64'd6);
        tick();
        cdb(1'b0, 5'd0, 64'd0);
        for (int t = 20; t < 23; t++) begin
            tick();
            chk("t5_order", 64'(bus.iss_tag_o), 64'(t));
            chk("t5_c", bus.iss_c_o, 64'd6);
        end
        tick();

        // flush with a concurrent dispatch
        bus.iss_rdy_i = 1'b0;
        for (int t = 24; t < 28; t++) begin
            disp(5'(t), 4'hF, 64'(t), 64'd0, 64'd0, 64'd0, 20'h0);
            tick();
        end
        chk("t6_pre", 64'(count), 64'd3);
        flush = 1'b1;
        disp(5'd28, 4'hF, 64'd28, 64'd0, 64'd0, 64'd0, 20'h0);
        tick();
        flush = 1'b0;
        bus.disp_v_i = 1'b0;
        chk("t6_cnt", 64'(count), 64'd0);
        chk("t6_v", 64'(bus.iss_v_o), 64'd0);
        chk("t6_rdy", 64'(bus.disp_rdy_o), 64'd1);
        bus.iss_rdy_i = 1'b1;
        tick();
        tick();
        chk("t6_none", 64'(bus.iss_v_o), 64'd0);

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            flush = ($urandom_range(0, 59) == 0);
            bus.iss_rdy_i = ($urandom_range(0, 9) < 7);
            bus.disp_v_i = ($urandom_range(0, 9) < 6);
            bus.disp_inst_i = $urandom;
            bus.disp_tag_i = 5'($urandom);
            for (int k = 0; k < 4; k++) begin
                bus.disp_opv_i[k] = ($urandom_range(0, 9) < 7);
                bus.disp_opd_i[k*64 +: 64] = {$urandom, $urandom};
                bus.disp_opt_i[k*5 +: 5] = 5'($urandom_range(0, 7));
            end
            cdb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                {$urandom, $urandom});
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
